// File: rtl/ddr4_app_pkg.sv
// Shared constants for the DDR4 app-interface responder.
// Command encodings, address shift and err_flags bit positions.
package ddr4_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int BEAT_ADDR_SHIFT = 3;

  localparam int ERR_ILLEGAL_CMD = 0;
  localparam int ERR_WDF_END     = 1;

endpackage

// File: rtl/app_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered count.
// Ports: push/push_data in, pop in, pop_data (head) out, count out.
module app_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr4_app_responder.sv
// BRAM-backed responder for the MIG DDR4 app_* user interface.
// Ports: app_* cmd/wdf/rd channels, init_calib_complete, err_flags.
module ddr4_app_responder
  import ddr4_app_pkg::*;
#(
  parameter int ADDR_WIDTH   = 29,
  parameter int DATA_WIDTH   = 128,
  parameter int MEM_AW       = 10,
  parameter int CMD_DEPTH    = 4,
  parameter int WDF_DEPTH    = 4,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int STALL_PERIOD = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    init_calib_complete,
  input  logic                    app_en,
  input  logic [2:0]              app_cmd,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  output logic                    app_rdy,
  input  logic                    app_wdf_wren,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic [1:0]              err_flags
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int CQW  = 1 + MEM_AW;
  localparam int WQW  = NB + DATA_WIDTH;
  localparam int CCW  = $clog2(CMD_DEPTH) + 1;
  localparam int WCW  = $clog2(WDF_DEPTH) + 1;
  localparam int CALW = $clog2(CALIB_CYCLES + 1);

  logic              calib_done;
  logic [CALW-1:0]   calib_cnt;
  logic              stall_cycle;

  logic              cmd_acc;
  logic              cmd_legal;
  logic [CQW-1:0]    cq_in;
  logic [CQW-1:0]    cq_head;
  logic [CCW-1:0]    cmd_count;
  logic              wdf_acc;
  logic [WQW-1:0]    wq_head;
  logic [WCW-1:0]    wdf_count;

  logic              head_read;
  logic [MEM_AW-1:0] head_beat;
  logic [NB-1:0]     wq_mask;
  logic [DATA_WIDTH-1:0] wq_data;
  logic              exec_wr;
  logic              exec_rd;

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
  logic [RD_LATENCY:0]   rd_vld;
  logic [DATA_WIDTH-1:0] rd_pipe [RD_LATENCY+1];

  logic unused_addr;
  assign unused_addr = ^{app_addr[ADDR_WIDTH-1:BEAT_ADDR_SHIFT+MEM_AW],
                         app_addr[BEAT_ADDR_SHIFT-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_cnt  <= '0;
      calib_done <= 1'b0;
    end else if (!calib_done) begin
      if (calib_cnt == CALW'(CALIB_CYCLES - 1)) calib_done <= 1'b1;
      else calib_cnt <= calib_cnt + 1'b1;
    end
  end

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      localparam int SW = $clog2(STALL_PERIOD + 1);
      logic [SW-1:0] stall_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= '0;
        else if (calib_done)
          stall_cnt <= (stall_cnt == SW'(STALL_PERIOD - 1)) ?
                       '0 : stall_cnt + 1'b1;
      end
      assign stall_cycle = calib_done &&
                           (stall_cnt == SW'(STALL_PERIOD - 1));
    end else begin : g_nostall
      assign stall_cycle = 1'b0;
    end
  endgenerate

  assign app_rdy = calib_done & (cmd_count != CCW'(CMD_DEPTH))
                 & ~stall_cycle;
  assign app_wdf_rdy = calib_done & (wdf_count != WCW'(WDF_DEPTH));

  assign cmd_acc   = app_en & app_rdy;
  assign cmd_legal = (app_cmd == CMD_WRITE) | (app_cmd == CMD_READ);
  assign cq_in     = {app_cmd == CMD_READ,
                      app_addr[BEAT_ADDR_SHIFT +: MEM_AW]};
  assign wdf_acc   = app_wdf_wren & app_wdf_rdy;

  app_sync_fifo #(.WIDTH(CQW), .DEPTH(CMD_DEPTH)) u_cmd_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_acc & cmd_legal),
    .push_data (cq_in),
    .pop       (exec_wr | exec_rd),
    .pop_data  (cq_head),
    .count     (cmd_count)
  );

  app_sync_fifo #(.WIDTH(WQW), .DEPTH(WDF_DEPTH)) u_wdf_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wdf_acc),
    .push_data ({app_wdf_mask, app_wdf_data}),
    .pop       (exec_wr),
    .pop_data  (wq_head),
    .count     (wdf_count)
  );

  assign {head_read, head_beat} = cq_head;
  assign {wq_mask, wq_data}     = wq_head;

  // A write at the head waits for its data and blocks everything behind
  // it, so a later read always sees the completed write.
  assign exec_wr = (cmd_count != '0) & ~head_read & (wdf_count != '0);
  assign exec_rd = (cmd_count != '0) & head_read;

  always_ff @(posedge clk) begin
    if (exec_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (!wq_mask[b]) mem[head_beat][8*b +: 8] <= wq_data[8*b +: 8];
      end
    end
  end

  // Stage 0 captures the BRAM word at the dequeue edge; RD_LATENCY more
  // stages follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      rd_vld     <= {rd_vld[RD_LATENCY-1:0], exec_rd};
      rd_pipe[0] <= mem[head_beat];
      for (int i = 1; i <= RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flags <= '0;
    end else begin
      if (cmd_acc & ~cmd_legal)    err_flags[ERR_ILLEGAL_CMD] <= 1'b1;
      if (wdf_acc & ~app_wdf_end)  err_flags[ERR_WDF_END]     <= 1'b1;
    end
  end

  assign init_calib_complete = calib_done;
  assign app_rd_data         = rd_pipe[RD_LATENCY];
  assign app_rd_data_valid   = rd_vld[RD_LATENCY];
  assign app_rd_data_end     = rd_vld[RD_LATENCY];

endmodule

// File: tb/tb_ddr4_app_responder.sv
// Directed self-checking bench for ddr4_app_responder.
// Default parameters; expected values are hand-computed constants.
module tb_ddr4_app_responder;
  import ddr4_app_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init_calib_complete;
  logic         app_en = 1'b0;
  logic [2:0]   app_cmd = '0;
  logic [28:0]  app_addr = '0;
  logic         app_rdy;
  logic         app_wdf_wren = 1'b0;
  logic [127:0] app_wdf_data = '0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_end = 1'b0;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic [1:0]   err_flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr4_app_responder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .err_flags           (err_flags)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [28:0] a);
    int n = 0;
    app_en = 1'b1;
    app_cmd = c;
    app_addr = a;
    while (!app_rdy && n < 200) begin
      tick();
      n++;
    end
    chk("cmd_rdy", app_rdy, 1);
    tick();
    app_en = 1'b0;
  endtask

  task automatic send_wdf(input logic [127:0] d, input logic [15:0] m,
                          input logic e);
    int n = 0;
    app_wdf_wren = 1'b1;
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_end = e;
    while (!app_wdf_rdy && n < 200) begin
      tick();
      n++;
    end
    chk("wdf_rdy", app_wdf_rdy, 1);
    tick();
    app_wdf_wren = 1'b0;
  endtask

  task automatic wait_rd(input string tag, input logic [127:0] exp);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!app_rd_data_valid && n < 20);
    chk({tag, "_lat"}, n, 5);
    chk({tag, "_end"}, app_rd_data_end, 1);
    chk({tag, "_data"}, app_rd_data, exp);
    tick();
    chk({tag, "_1cyc"}, app_rd_data_valid, 0);
  endtask

  task automatic wait_calib;
    int n = 0;
    while (!init_calib_complete && n < 200) begin
      tick();
      n++;
    end
    chk("calib_up", init_calib_complete, 1);
  endtask

  localparam logic [127:0] D0 = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [127:0] D_OLD = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
  localparam logic [127:0] D_NEW = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;

  initial begin
    int acc;
    int n;
    int bad;

    tick();
    tick();
    chk("rst_calib", init_calib_complete, 0);
    chk("rst_rdy", app_rdy, 0);
    chk("rst_wdf_rdy", app_wdf_rdy, 0);
    chk("rst_valid", app_rd_data_valid, 0);
    chk("rst_end", app_rd_data_end, 0);
    chk("rst_data", app_rd_data, 0);
    chk("rst_err", err_flags, 0);
    rst_n = 1'b1;

    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) begin
        chk("calib_63", init_calib_complete, 0);
        chk("rdy_63", app_rdy, 0);
        chk("wdf_rdy_63", app_wdf_rdy, 0);
      end
    end
    chk("calib_64", init_calib_complete, 1);
    chk("rdy_64", app_rdy, 1);
    chk("wdf_rdy_64", app_wdf_rdy, 1);

    send_wdf(D0, 16'h0000, 1'b1);
    send_cmd(CMD_WRITE, 29'h10);
    send_cmd(CMD_READ, 29'h10);
    wait_rd("basic", D0);

    send_wdf(D_OLD, 16'h0000, 1'b1);
    send_cmd(CMD_WRITE, 29'h20);
    tick();
    tick();
    send_wdf(D_NEW, 16'h0000, 1'b1);
    tick();
    tick();
    tick();
    send_cmd(CMD_WRITE, 29'h20);
    send_cmd(CMD_READ, 29'h20);
    wait_rd("early_wdf", D_NEW);

    send_wdf({128{1'b1}}, 16'h0000, 1'b1);
    send_cmd(CMD_WRITE, 29'h30);
    send_wdf(128'h0, 16'hFF00, 1'b1);
    send_cmd(CMD_WRITE, 29'h30);
    send_cmd(CMD_READ, 29'h30);
    wait_rd("mask", {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

    acc = 0;
    app_en = 1'b1;
    app_cmd = CMD_WRITE;
    for (int i = 0; i < 8; i++) begin
      app_addr = 29'h40 + 29'(acc * 8);
      if (app_rdy) acc++;
      tick();
    end
    app_en = 1'b0;
    chk("q_accepts", acc, 4);
    chk("q_full_rdy", app_rdy, 0);
    for (int i = 0; i < 4; i++)
      send_wdf({4{32'hA000_0000 + 32'(i)}}, 16'h0000, 1'b1);
    tick();
    tick();
    tick();
    chk("q_drained", app_rdy, 1);
    app_en = 1'b1;
    app_cmd = CMD_READ;
    for (int i = 0; i < 4; i++) begin
      app_addr = 29'h40 + 29'(i * 8);
      chk("b2b_rdy", app_rdy, 1);
      tick();
    end
    app_en = 1'b0;
    n = 0;
    while (!app_rd_data_valid && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_first", n, 2);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", app_rd_data_valid, 1);
      chk("b2b_data", app_rd_data, {4{32'hA000_0000 + 32'(i)}});
      tick();
    end
    chk("b2b_after", app_rd_data_valid, 0);

    chk("err_pre", err_flags, 0);
    send_cmd(3'b111, 29'h50);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (app_rd_data_valid) bad++;
      tick();
    end
    chk("illegal_novalid", bad, 0);
    chk("illegal_err", err_flags, 2'b01);

    send_cmd(CMD_READ, 29'h10);
    tick();
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (app_rd_data_valid) bad++;
    end
    chk("rst_novalid", bad, 0);
    chk("rst_err_clr", err_flags, 0);
    chk("rst_recal", init_calib_complete, 0);
    chk("rst_rdy_low", app_rdy, 0);
    wait_calib();

    send_wdf(D_NEW, 16'h0000, 1'b0);
    send_cmd(CMD_WRITE, 29'h60);
    send_cmd(CMD_READ, 29'h60);
    wait_rd("wdf_end_lo", D_NEW);
    chk("wdf_end_err", err_flags, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr4_app_responder.md
Name: ddr4_app_responder

Overview:
- Synthesizable stand-in for the MIG DDR4 user interface; it is the responder side of the app_* protocol that the DDR4 test engine drives.
- Accepts app_en commands and app_wdf write data, and stores them in an internal block RAM.
- Returns read data on app_rd_data, strictly in order, after a fixed latency.
- Used in simulation and on MIG-less bring-up builds so the test engine and pipe FIFOs run without DDR4 calibration.

Parameters:
- ADDR_WIDTH, 29, app_addr width.
- DATA_WIDTH, 128, app data width (one beat per command).
- MEM_AW, 10, log2 of memory depth in beats.
- CMD_DEPTH, 4, command queue entries (power of 2).
- WDF_DEPTH, 4, write-data queue entries (power of 2).
- RD_LATENCY, 4, cycles from read dequeue to app_rd_data_valid (≥1).
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.
- STALL_PERIOD, 0, forces app_rdy low one cycle in every STALL_PERIOD cycles; 0 disables.

Ports:
- clk  in  1  sole clock (ui clock domain).
- rst_n  in  1  asynchronous, active-low reset.
- init_calib_complete  out  1  calibration-done indication.
- app_en  in  1  command valid.
- app_cmd  in  3  3'b000 = write, 3'b001 = read.
- app_addr  in  ADDR_WIDTH  address in DQ-width units (8 units per beat).
- app_rdy  out  1  command accept.
- app_wdf_wren  in  1  write data valid.
- app_wdf_data  in  DATA_WIDTH  write data.
- app_wdf_mask  in  DATA_WIDTH/8  per-byte mask; 1 = byte NOT written.
- app_wdf_end  in  1  last beat; must be 1 on every beat.
- app_wdf_rdy  out  1  write data accept.
- app_rd_data  out  DATA_WIDTH  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  last read beat; equals app_rd_data_valid.
- err_flags  out  2  sticky error bits: [0] = illegal cmd, [1] = wdf_end low.

Behaviour:
- Reset values: all outputs 0, queues empty, read pipeline empty, calib counter 0, stall counter 0. Memory contents are not cleared.
- Reset asserted mid-operation: in-flight reads are discarded and pending writes are lost. No read valid is emitted after rst_n deasserts until a new read is accepted.
- Calibration: counter runs from reset release. init_calib_complete goes 1 at cycle CALIB_CYCLES and stays 1. Before that, app_rdy = app_wdf_rdy = 0.
- app_rdy = calib_done & (cmd_count < CMD_DEPTH) & ~stall_cycle. Computed combinationally from registered state only, never from app_en.
- app_wdf_rdy = calib_done & (wdf_count < WDF_DEPTH).
- Command accept: app_en & app_rdy. Illegal cmd: sets err_flags[0] and is dropped (not queued).
- Data accept: app_wdf_wren & app_wdf_rdy. If app_wdf_end = 0, set err_flags[1] and still store the data.
- Write data may arrive before, with, or after its write command.
- Beat index = app_addr[3 +: MEM_AW]; higher address bits alias (wrap).
- Execution: at most one command per cycle, from the queue head, in order.
  - Write at head: executes only when the wdf queue is non-empty. Pops both queues and writes unmasked bytes at that edge. With wdf empty, the head stalls and blocks later reads, which preserves read-after-write ordering.
  - Read at head: pops and enters the RD_LATENCY pipeline.
- Latency: read accepted at edge T on an empty queue dequeues at T+1. app_rd_data_valid and app_rd_data_end are high in cycle T+1+RD_LATENCY, each for exactly one cycle per read.
- Read data has no backpressure. Back-to-back reads give consecutive valid cycles.
- Queue full and dequeue in the same cycle: app_rdy stays 0 for that cycle (no bypass). Same rule for wdf.
- Stall counter counts 0..STALL_PERIOD-1 from calib_done. stall_cycle is high when the count = STALL_PERIOD-1.
- Counters wrap using MEM_AW / log2(depth)+1 bit widths. There is no overflow of counts, because accept is gated on not-full.

Decomposition:
- Package ddr4_app_pkg holds CMD_WRITE = 3'b000, CMD_READ = 3'b001, BEAT_ADDR_SHIFT = 3, and the err_flags bit indices.
- One sub-module, app_sync_fifo (parameterised width/depth, first-word-fall-through, registered count), instantiated twice: command queue {cmd, addr} and wdf queue {mask, data}.

Test Plan:
- Reset release → init_calib_complete rises at exactly cycle 64. app_rdy = app_wdf_rdy = 0 before that, and 1 after.
- Write addr 0x10 with data 0x0123..CDEF, mask 0, then read addr 0x10 → one valid beat returning the same data, RD_LATENCY+1 = 5 cycles after read accept.
- Write data presented 3 cycles before its command, then read of the same address issued immediately → read returns the new data, never stale data.
- Write 0xFF..FF, then write 0x00..00 with mask 16'hFF00, then read → returns 0xFF..FF_00..00 (upper 8 bytes kept).
- 8 commands issued back-to-back with CMD_DEPTH = 4, writes with no data → app_rdy drops after 4 accepts. Supplying data drains the queue in order; 4 subsequent reads give 4 consecutive valid cycles.
- app_cmd = 3'b111 → err_flags = 2'b01, no read valid ever. rst_n pulsed low mid-read → valid never asserts for that read and err_flags clear to 0.
